microprogram_sequencer: RTL and testbench

Control-address sequencer for the core's microcoded control unit. Sits directly downstream of mapping_block and consumes its 16-bit map_addr to dispatch the decoded instruction's microroutine. Each cycle it selects the next control-store address (CAR) from one of four sources: increment, map_addr, the control word's next-address field, or a return stack. The control store reads seq_op/next_addr at the current CAR and feeds them back combinationally in the same cycle.

---
 rtl/microprogram_sequencer.sv | 170 +++++++++++++++++
 tb/tb_microprogram_sequencer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/microprogram_sequencer.sv
// Control-address sequencer: picks the next CAR from increment, map, next-address or return stack.
// Optional macro SEQ_SUBROUTINE_EN compiles in the CALL/RET return stack and stack_err.
module microprogram_sequencer #(
  parameter int          AW         = 8,
  parameter int unsigned FETCH_ADDR = 0
`ifdef SEQ_SUBROUTINE_EN
  , parameter int        STACK_DEPTH = 4
`endif
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          stall,
  input  logic [2:0]    seq_op,
  input  logic [AW-1:0] next_addr,
  input  logic [15:0]   map_addr,
  input  logic          z_flag,
  output logic [AW-1:0] car,
  output logic          running,
  output logic          done,
  output logic          stack_err
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  localparam logic [2:0] OP_NEXT = 3'd0;
  localparam logic [2:0] OP_MAP  = 3'd1;
  localparam logic [2:0] OP_JUMP = 3'd2;
  localparam logic [2:0] OP_BRZ  = 3'd3;
  localparam logic [2:0] OP_BRNZ = 3'd4;
  localparam logic [2:0] OP_CALL = 3'd5;
  localparam logic [2:0] OP_RET  = 3'd6;
  localparam logic [2:0] OP_HALT = 3'd7;

  localparam logic [AW-1:0] FETCH = AW'(FETCH_ADDR);

  state_t        state_q, state_d;
  logic [AW-1:0] car_q, car_d;
  logic          done_q, done_d;
  logic [AW-1:0] car_inc;

  assign car_inc = car_q + 1'b1;

`ifdef SEQ_SUBROUTINE_EN
  localparam int SPW = $clog2(STACK_DEPTH + 1);
  localparam int SIW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [AW-1:0]  stack_q [STACK_DEPTH];
  logic [AW-1:0]  stack_d [STACK_DEPTH];
  logic [SPW-1:0] sp_q, sp_d;
  logic [SPW-1:0] sp_dec;
  logic           err_q, err_d;

  assign sp_dec = sp_q - 1'b1;
`endif

  // Only the low AW bits of the dispatch address select a microroutine.
  if (AW < 16) begin : g_map_hi
    logic unused_map_hi;
    assign unused_map_hi = ^map_addr[15:AW];
  end

  always_comb begin
    state_d = state_q;
    car_d   = car_q;
    done_d  = 1'b0;
`ifdef SEQ_SUBROUTINE_EN
    stack_d = stack_q;
    sp_d    = sp_q;
    err_d   = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        car_d = FETCH;
        if (start) begin
          state_d = S_RUN;
`ifdef SEQ_SUBROUTINE_EN
          sp_d    = '0;
          err_d   = 1'b0;
`endif
        end
      end
      S_RUN: begin
        if (!stall) begin
          case (seq_op)
            OP_NEXT: car_d = car_inc;
            OP_MAP:  car_d = map_addr[AW-1:0];
            OP_JUMP: car_d = next_addr;
            OP_BRZ:  car_d = z_flag ? next_addr : car_inc;
            OP_BRNZ: car_d = z_flag ? car_inc : next_addr;
            OP_CALL: begin
`ifdef SEQ_SUBROUTINE_EN
              if (sp_q == SPW'(STACK_DEPTH)) begin
                err_d   = 1'b1;
                state_d = S_IDLE;
                car_d   = FETCH;
              end else begin
                stack_d[sp_q[SIW-1:0]] = car_inc;
                sp_d  = sp_q + 1'b1;
                car_d = next_addr;
              end
`else
              car_d = next_addr;
`endif
            end
            OP_RET: begin
`ifdef SEQ_SUBROUTINE_EN
              if (sp_q == '0) begin
                err_d   = 1'b1;
                state_d = S_IDLE;
                car_d   = FETCH;
              end else begin
                car_d = stack_q[sp_dec[SIW-1:0]];
                sp_d  = sp_dec;
              end
`else
              car_d = car_inc;
`endif
            end
            OP_HALT: begin
              state_d = S_IDLE;
              car_d   = FETCH;
              done_d  = 1'b1;
            end
            default: car_d = car_q;
          endcase
        end
      end
      default: begin
        state_d = S_IDLE;
        car_d   = FETCH;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      car_q   <= FETCH;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      car_q   <= car_d;
      done_q  <= done_d;
    end
  end

`ifdef SEQ_SUBROUTINE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stack_q <= '{default: '0};
      sp_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      stack_q <= stack_d;
      sp_q    <= sp_d;
      err_q   <= err_d;
    end
  end

  assign stack_err = err_q;
`else
  assign stack_err = 1'b0;
`endif

  assign car     = car_q;
  assign running = (state_q == S_RUN);
  assign done    = done_q;

endmodule

// File: tb/tb_microprogram_sequencer.sv
// Scoreboard bench for microprogram_sequencer: directed scenarios then random ops vs. a queue-based model.
// Honours SEQ_SUBROUTINE_EN the same way the design does.
module tb_microprogram_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       stall = 1'b0;
  logic [2:0] seq_op = 3'd0;
  logic [7:0] next_addr = 8'h00;
  logic [15:0] map_addr = 16'h0000;
  logic       z_flag = 1'b0;
  logic [7:0] car;
  logic       running, done, stack_err;

  microprogram_sequencer #(.AW(8), .FETCH_ADDR(0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stall(stall), .seq_op(seq_op),
    .next_addr(next_addr), .map_addr(map_addr), .z_flag(z_flag),
    .car(car), .running(running), .done(done), .stack_err(stack_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int car;
    int running;
    int done;
    int err;
  } exp_t;

  exp_t exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: microaddress as an int modulo 256, return stack as a queue.
  int m_car = 0;
  int m_running = 0;
  int m_done = 0;
  int m_err = 0;
  int m_stack[$];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_car = 0; m_running = 0; m_done = 0; m_err = 0;
    m_stack.delete();
  endtask

  task automatic model_abort();
    m_err = 1; m_running = 0; m_car = 0;
  endtask

  task automatic model_step(input int st, input int sl, input int op, input int na,
                            input int mp, input int z);
    m_done = 0;
    if (m_running == 0) begin
      m_car = 0;
      if (st != 0) begin
        m_running = 1;
        m_err = 0;
        m_stack.delete();
      end
    end else if (sl == 0) begin
      case (op)
        0: m_car = (m_car + 1) % 256;
        1: m_car = mp % 256;
        2: m_car = na;
        3: m_car = (z != 0) ? na : (m_car + 1) % 256;
        4: m_car = (z != 0) ? (m_car + 1) % 256 : na;
        5: begin
`ifdef SEQ_SUBROUTINE_EN
          if (m_stack.size() == 4) model_abort();
          else begin
            m_stack.push_back((m_car + 1) % 256);
            m_car = na;
          end
`else
          m_car = na;
`endif
        end
        6: begin
`ifdef SEQ_SUBROUTINE_EN
          if (m_stack.size() == 0) model_abort();
          else m_car = m_stack.pop_back();
`else
          m_car = (m_car + 1) % 256;
`endif
        end
        default: begin
          m_running = 0; m_car = 0; m_done = 1;
        end
      endcase
    end
  endtask

  task automatic step(input int st, input int sl, input int op, input int na,
                      input int mp, input int z);
    exp_t e;
    @(negedge clk);
    start = st[0]; stall = sl[0]; seq_op = op[2:0];
    next_addr = na[7:0]; map_addr = mp[15:0]; z_flag = z[0];
    model_step(st, sl, op, na, mp, z);
    e.car = m_car; e.running = m_running; e.done = m_done; e.err = m_err;
    exp_q.push_back(e);
  endtask

  // Monitor: every clock edge the DUT presents a new CAR; compare against the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("car", int'(car), e.car);
        chk("running", int'(running), e.running);
        chk("done", int'(done), e.done);
        chk("stack_err", int'(stack_err), e.err);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, pending %0d expected 0", exp_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    int op;
    #12;
    chk("rst_car", int'(car), 0);
    chk("rst_running", int'(running), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(stack_err), 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // start, NEXT x3
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    // MAP from car 5, wrap at 0xFF
    step(0, 0, 2, 8'h05, 0, 0);
    step(0, 0, 1, 0, 16'h0123, 0);
    step(0, 0, 2, 8'hFF, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    // BRZ / BRNZ both ways
    step(0, 0, 3, 8'h40, 0, 1);
    step(0, 0, 2, 8'h10, 0, 0);
    step(0, 0, 3, 8'h40, 0, 0);
    step(0, 0, 4, 8'h40, 0, 1);
    step(0, 0, 4, 8'h40, 0, 0);
    // stalled HALT, then released; then start in the cycle done is high
    for (int i = 0; i < 4; i++) step(0, 1, 7, 0, 0, 0);
    step(0, 0, 7, 0, 0, 0);
    step(1, 0, 7, 0, 0, 0);
    step(0, 0, 7, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    // CALL / RET, then overflow with five nested CALLs
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 2, 8'h20, 0, 0);
    step(0, 0, 5, 8'h80, 0, 0);
    step(0, 0, 6, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 5, 8'h90 + i, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    // RET with empty stack
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 6, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);

    // Randomised run
    for (int i = 0; i < 2000; i++) begin
      op = $urandom_range(0, 7);
      if (op == 7 && ($urandom % 3) != 0) op = 0;
      step((m_running == 0) ? int'(($urandom % 3) == 0) : int'(($urandom % 8) == 0),
           int'(($urandom % 8) == 0), op, $urandom_range(0, 255),
           $urandom_range(0, 65535), $urandom_range(0, 1));
    end

    // Asynchronous reset in the middle of a routine
    step(0, 0, 7, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 2, 8'h37, 0, 0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_car", int'(car), 0);
    chk("async_running", int'(running), 0);
    chk("async_done", int'(done), 0);
    chk("async_err", int'(stack_err), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #2;
    chk("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
